// File: rtl/fir_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_mac_lane                                                 |
// | Description : One multiply-accumulate lane of the 4-lane FIR datapath.     |
// |               A sample strobe shifts the input into a TAPS-deep delay line |
// |               and the lane then multiplies one tap per clock against a     |
// |               writable coefficient bank. The result is scaled, limited to  |
// |               16 bits and presented with a one-clock strobe.               |
// | Options     : FIR_MAC_SAT_EN - clamp the scaled sum to 16 bits instead of  |
// |               two's-complement wrap.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_mac_lane #(
  parameter int TAPS   = 10,
  parameter int ADDR_W = 4,
  parameter int SHIFT  = 15
) (
  input  logic                iClk12M,
  input  logic                iRsn,
  input  logic                iEnSample600k,
  input  logic signed [15:0]  iFirIn,
  input  logic                iCoeffWr,
  input  logic [ADDR_W-1:0]   iCoeffAddr,
  input  logic signed [15:0]  iCoeffData,
  output logic signed [15:0]  oMac,
  output logic                oEnDelay,
  output logic                oBusy,
  output logic                oOverrun
);

  // Accumulator is wide enough that TAPS full-scale products cannot overflow.
  localparam int                       c_ACC_W    = 32 + $clog2(TAPS);
  localparam logic [ADDR_W-1:0]        c_LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]          c_TAPS_EXT = (ADDR_W + 1)'(TAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     state_q;
  state_t                     state_d;

  logic signed [15:0]         dly_q  [TAPS];
  logic signed [15:0]         coef_q [TAPS];
  logic signed [c_ACC_W-1:0]  acc_q;
  logic [ADDR_W-1:0]          tap_q;
  logic signed [15:0]         mac_q;
  logic signed [15:0]         mac_d;
  logic                       en_q;
  logic                       ovr_q;

  logic                       w_start;
  logic                       w_coef_we;
  logic signed [15:0]         w_tap_smp;
  logic signed [15:0]         w_tap_coef;
  logic signed [31:0]         w_prod;
  logic signed [c_ACC_W-1:0]  w_prod_ext;

  // A strobe only starts a computation when the lane is idle.
  assign w_start    = iEnSample600k && (state_q == S_IDLE);
  // Coefficients are frozen while a computation is in flight.
  assign w_coef_we  = iCoeffWr && (state_q == S_IDLE) &&
                      ({1'b0, iCoeffAddr} < c_TAPS_EXT);

  assign w_tap_smp  = dly_q[tap_q];
  assign w_tap_coef = coef_q[tap_q];
  assign w_prod     = 32'(w_tap_smp) * 32'(w_tap_coef);
  assign w_prod_ext = c_ACC_W'(w_prod);

`ifdef FIR_MAC_SAT_EN
  localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'(32767);
  localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = c_ACC_W'(-32768);

  logic signed [c_ACC_W-1:0]  w_shifted;

  assign w_shifted = acc_q >>> SHIFT;

  // Clamp the scaled sum into the signed 16-bit range.
  always_comb begin
    mac_d = w_shifted[15:0];
    if (w_shifted > c_SAT_MAX) begin
      mac_d = 16'sh7FFF;
    end else if (w_shifted < c_SAT_MIN) begin
      mac_d = 16'sh8000;
    end
  end
`else
  // Taking the 16 bits starting at SHIFT equals truncating acc >>> SHIFT.
  assign mac_d = acc_q[SHIFT +: 16];
`endif

  // State register.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> MAC (TAPS clocks) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (iEnSample600k) state_d = S_MAC;
      S_MAC:  if (tap_q == c_LAST_TAP) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay line, newest sample at index 0, shifted only on an accepted strobe.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < TAPS; i++) dly_q[i] <= '0;
    end else if (w_start) begin
      dly_q[0] <= iFirIn;
      for (int i = 1; i < TAPS; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Coefficient bank, written only in IDLE with an in-range address.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (w_coef_we) begin
      coef_q[iCoeffAddr] <= iCoeffData;
    end
  end

  // Accumulator and tap counter: cleared on start, one product per MAC clock.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      acc_q <= '0;
      tap_q <= '0;
    end else if (w_start) begin
      acc_q <= '0;
      tap_q <= '0;
    end else if (state_q == S_MAC) begin
      acc_q <= acc_q + w_prod_ext;
      tap_q <= tap_q + ADDR_W'(1);
    end
  end

  // Output register and one-clock result strobe.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      mac_q <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= 1'b0;
      if (state_q == S_DONE) begin
        mac_q <= mac_d;
        en_q  <= 1'b1;
      end
    end
  end

  // Sticky overrun: any strobe that arrives while the lane is busy.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      ovr_q <= 1'b0;
    end else if (iEnSample600k && (state_q != S_IDLE)) begin
      ovr_q <= 1'b1;
    end
  end

  assign oMac     = mac_q;
  assign oEnDelay = en_q;
  assign oBusy    = (state_q != S_IDLE);
  assign oOverrun = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_mac_lane                                              |
// | Description : Directed self-checking bench for fir_mac_lane. Expected      |
// |               results are hand-computed; FIR_MAC_SAT_EN selects the        |
// |               saturating or wrapping expectations.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_mac_lane;

  localparam int TAPS = 10;

  logic               clk = 1'b0;
  logic               rstn;
  logic               strobe;
  logic [15:0]        fir;
  logic               wr;
  logic [3:0]         addr;
  logic [15:0]        cdata;
  logic [15:0]        mac;
  logic               en;
  logic               busy;
  logic               ovr;

  int vectors     = 0;
  int miscompares = 0;

  fir_mac_lane #(
    .TAPS   (TAPS),
    .ADDR_W (4),
    .SHIFT  (15)
  ) dut (
    .iClk12M       (clk),
    .iRsn          (rstn),
    .iEnSample600k (strobe),
    .iFirIn        (fir),
    .iCoeffWr      (wr),
    .iCoeffAddr    (addr),
    .iCoeffData    (cdata),
    .oMac          (mac),
    .oEnDelay      (en),
    .oBusy         (busy),
    .oOverrun      (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
    wr = 1'b1; addr = a; cdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // mode 0: c[k] = (k+1)*0x0800, mode 1: all 0x4000, mode 2: all 0x8000
  task automatic load_coefs(input int mode);
    for (int k = 0; k < TAPS; k++) begin
      case (mode)
        0:       write_coef(4'(k), 16'((k + 1) * 16'h0800));
        1:       write_coef(4'(k), 16'h4000);
        default: write_coef(4'(k), 16'h8000);
      endcase
    end
  endtask

  // Asserts reset away from the clock edge and checks the outputs clear at once.
  task automatic do_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    check({tag, "_mac"},  32'(mac),  32'h0);
    check({tag, "_en"},   32'(en),   32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_ovr"},  32'(ovr),  32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // One sample: strobe, optional side action at edge E<act_at>, then check
  // latency, result, busy profile and the one-clock strobe width.
  // act_kind 1 = extra strobe with act_data, 2 = coefficient write.
  task automatic run_sample(input string tag, input logic [15:0] x, input logic [15:0] exp,
                            input int act_kind, input int act_at,
                            input logic [3:0] act_addr, input logic [15:0] act_data);
    int cycles;
    strobe = 1'b1; fir = x;
    @(posedge clk); #1;
    strobe = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'h1);
    cycles = 0;
    while (en !== 1'b1 && cycles < 40) begin
      if (act_kind == 1 && cycles == act_at - 1) begin
        strobe = 1'b1; fir = act_data;
      end
      if (act_kind == 2 && cycles == act_at - 1) begin
        wr = 1'b1; addr = act_addr; cdata = act_data;
      end
      @(posedge clk); #1;
      strobe = 1'b0; wr = 1'b0;
      cycles++;
      if (cycles == TAPS) check({tag, "_busy_last"}, 32'(busy), 32'h1);
    end
    check({tag, "_latency"}, 32'(cycles), 32'(TAPS + 1));
    check({tag, "_mac"},     32'(mac),    32'(exp));
    check({tag, "_busy_end"},32'(busy),   32'h0);
    @(posedge clk); #1;
    check({tag, "_en_width"}, 32'(en), 32'h0);
    repeat (7) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    int          cnt;

    rstn = 1'b0; strobe = 1'b0; fir = '0; wr = 1'b0; addr = '0; cdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mac",  32'(mac),  32'h0);
    check("rst_en",   32'(en),   32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovr",  32'(ovr),  32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a computation.
    load_coefs(0);
    strobe = 1'b1; fir = 16'h2000;
    @(posedge clk); #1;
    strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t1_busy_mid", 32'(busy), 32'h1);
    do_reset("t1_rst");
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (en) cnt++;
    end
    check("t1_no_strobe", 32'(cnt), 32'h0);
    load_coefs(0);
    run_sample("t1_zeroed", 16'h0000, 16'h0000, 0, 0, 4'h0, 16'h0);

    // Impulse response: 0x0200 * (n+1), then zero once it leaves the line.
    for (int n = 0; n <= TAPS; n++) begin
      e = (n < TAPS) ? 32'((n + 1) * 32'h200) : 32'h0;
      run_sample("t2_impulse", (n == 0) ? 16'h2000 : 16'h0000, e[15:0], 0, 0, 4'h0, 16'h0);
    end
    check("t2_ovr", 32'(ovr), 32'h0);

    // Overrun: a second strobe at E5 is dropped.
    run_sample("t4_first", 16'h1000, 16'h0100, 1, 5, 4'h0, 16'h7777);
    check("t4_ovr", 32'(ovr), 32'h1);
    run_sample("t4_next", 16'h0000, 16'h0200, 0, 0, 4'h0, 16'h0);

    // Coefficient writes: during MAC and out of range are ignored.
    write_coef(4'd12, 16'h7FFF);
    run_sample("t5_macwr", 16'h0000, 16'h0300, 2, 3, 4'd3, 16'h7FFF);
    run_sample("t5_c3_old", 16'h0000, 16'h0400, 0, 0, 4'h0, 16'h0);
    write_coef(4'd3, 16'h7FFF);
    run_sample("t5_s0", 16'h1000, 16'h0600, 0, 0, 4'h0, 16'h0);
    run_sample("t5_s1", 16'h0000, 16'h0800, 0, 0, 4'h0, 16'h0);
    run_sample("t5_s2", 16'h0000, 16'h0A00, 0, 0, 4'h0, 16'h0);
    run_sample("t5_c3_new", 16'h0000, 16'h17FF, 0, 0, 4'h0, 16'h0);

    // Step response.
    do_reset("t3_rst");
    load_coefs(1);
    for (int n = 1; n <= TAPS; n++) begin
      e = 32'(n * 32'h1000);
`ifdef FIR_MAC_SAT_EN
      if (e > 32'h7FFF) e = 32'h7FFF;
`endif
      run_sample("t3_step", 16'h2000, e[15:0], 0, 0, 4'h0, 16'h0);
    end

    // Negative full-scale operands: each product is +2^30.
    do_reset("t6_rst");
    load_coefs(2);
    for (int n = 1; n <= TAPS; n++) begin
`ifdef FIR_MAC_SAT_EN
      e = 32'h7FFF;
`else
      e = (n % 2 == 1) ? 32'h8000 : 32'h0;
`endif
      run_sample("t6_negext", 16'h8000, e[15:0], 0, 0, 4'h0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_lane.md
Name: fir_mac_lane

Overview:
- One multiply-accumulate lane of the 4-lane FIR datapath; sits directly upstream of the final-sum stage.
- On each 600 kHz sample strobe, shifts the new input into a TAPS-deep delay line and sequentially multiplies it against a writable coefficient bank, one tap per 12 MHz clock.
- Drives a scaled, saturated 16-bit partial sum (oMac) and a one-cycle oEnDelay pulse. These connect to one iMacN input and the iEnDelay input of the summing stage.

Parameters:
- TAPS, 10, taps handled by this lane; TAPS+2 must be ≤ 20, the clocks per sample period.
- ADDR_W, 4, coefficient address width; 2^ADDR_W ≥ TAPS.
- SHIFT, 15, arithmetic right shift applied to the accumulator before output (Q1.15 coefficients).

Ports:
- iClk12M  in  1  12 MHz system clock.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample600k  in  1  one-cycle new-sample strobe.
- iFirIn  in  16  signed input sample.
- iCoeffWr  in  1  coefficient write enable.
- iCoeffAddr  in  ADDR_W  coefficient index.
- iCoeffData  in  16  signed coefficient value.
- oMac  out  16  signed lane partial sum.
- oEnDelay  out  1  one-cycle strobe marking oMac as new.
- oBusy  out  1  high while in MAC or DONE.
- oOverrun  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous. It clears the delay line, all coefficients, the accumulator, the tap counter, oMac, oEnDelay, oBusy and oOverrun to 0, and forces state IDLE. A reset mid-computation aborts it; no oEnDelay is produced.
- State machine: IDLE -> MAC -> DONE -> IDLE.
- IDLE:
  - A strobe sampled at edge E0 shifts the delay line: d[0] <= iFirIn, d[k] <= d[k-1].
  - The same edge clears the accumulator and tap counter k, and moves to MAC.
- MAC:
  - On edges E1..E_TAPS: acc <= acc + d[k]*c[k], then k <= k+1.
  - The product is a signed 32-bit value. The accumulator is signed, 32 + ceil(log2(TAPS)) bits, and never overflows internally.
  - After the k = TAPS-1 edge, move to DONE.
- DONE, edge E_{TAPS+1}:
  - oMac <= sat16(acc >>> SHIFT), using an arithmetic shift.
  - oEnDelay <= 1 and the state returns to IDLE.
  - oEnDelay falls at the next edge. Pulse width is exactly 1 clock.
- Latency: oEnDelay is high in the cycle following E_{TAPS+1}, i.e. TAPS+1 clocks after the strobe edge.
- oMac holds its value between updates.
- oBusy is high from the cycle after E0 through the cycle after E_TAPS.
- The delay line uses the newest-first convention; the output equals sum over k of d[k]*c[k], where d[0] is the latest sample.
- Strobe while busy (MAC or DONE):
  - The sample is dropped; the delay line is unchanged and the computation continues unaffected.
  - oOverrun <= 1 and stays set until reset.
- Coefficient writes:
  - Accepted only in IDLE with iCoeffAddr < TAPS: c[addr] <= iCoeffData on that edge.
  - Writes while busy, or with addr ≥ TAPS, are ignored; they do not set oOverrun.
  - If a write and a strobe arrive on the same IDLE edge, both take effect. The running computation uses the coefficient values as they stand after that edge.

Optional Feature:
- Macro: FIR_MAC_SAT_EN.
- Defined: sat16 clamps the shifted accumulator to the range [-32768, 32767], i.e. 0x8000..0x7FFF.
- Undefined: sat16 is a plain truncation to bits [15:0] of the shifted value, giving two's-complement wrap. This saves area when coefficient gain is guaranteed ≤ 1.

Test Plan:
1. Reset asserted mid-MAC (strobe, then iRsn low at E5) -> all outputs 0 immediately; no oEnDelay; next strobe after release computes from a zeroed delay line.
2. Impulse response: load c[k] = (k+1)*0x0800; feed 0x2000 once, then 0x0000 every 20 clocks -> successive oMac values 0x0200, 0x0400, ..., 0x1400, then 0x0000; each oEnDelay exactly 1 clock wide, 11 clocks after its strobe.
3. Step response: all c = 0x4000; iFirIn = 0x2000 on every strobe -> oMac = 0x1000, 0x2000, ..., 0x7000, then 0x7FFF from the 8th output on with FIR_MAC_SAT_EN defined, versus 0x8000, 0x9000, 0xA000 without it.
4. Overrun: second strobe 5 clocks after the first -> oOverrun = 1; first result is correct; the dropped sample never appears in later outputs.
5. Coefficient write to addr 3 during MAC, and to addr 12 in IDLE -> both ignored; an IDLE write to addr 3 of 0x7FFF is used by the next computation.
6. Negative extremes: all c = 0x8000, iFirIn = 0x8000 for 10 samples -> final oMac = 0x7FFF with saturation enabled, 0x0000 without.
